// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-YUV frame encoder: reads packed 24-bit RGB from SRAM, converts to BT.601 YUV,
// halves chroma horizontally and writes planar Y/U/V back, 16 cycles per 4 pixels.
module rgb_to_yuv_encoder #(
  parameter logic [17:0] Y_START    = 18'd0,
  parameter logic [17:0] U_START    = 18'd38400,
  parameter logic [17:0] V_START    = 18'd57600,
  parameter logic [17:0] RGB_START  = 18'd146944,
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Stop,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int          N_ITER = IMG_WIDTH * IMG_HEIGHT / 4;
  localparam logic [15:0] LAST_K = 16'(N_ITER - 1);

  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_RD0  = 5'd1;
  localparam logic [4:0] S_RD1  = 5'd2;
  localparam logic [4:0] S_RD2  = 5'd3;
  localparam logic [4:0] S_RD3  = 5'd4;
  localparam logic [4:0] S_RD4  = 5'd5;
  localparam logic [4:0] S_RD5  = 5'd6;
  localparam logic [4:0] S_CAP0 = 5'd7;
  localparam logic [4:0] S_CAP1 = 5'd8;
  localparam logic [4:0] S_CMP0 = 5'd9;
  localparam logic [4:0] S_CMP1 = 5'd10;
  localparam logic [4:0] S_CMP2 = 5'd11;
  localparam logic [4:0] S_CMP3 = 5'd12;
  localparam logic [4:0] S_WR0  = 5'd13;
  localparam logic [4:0] S_WR1  = 5'd14;
  localparam logic [4:0] S_WR2  = 5'd15;
  localparam logic [4:0] S_WR3  = 5'd16;
  localparam logic [4:0] S_DONE = 5'd17;

  logic [4:0]  r_state;
  logic [15:0] r_k;
  logic [17:0] r_rgb_addr;
  logic [17:0] r_y_addr;

  logic [7:0]         r_r  [4];
  logic [7:0]         r_g  [4];
  logic [7:0]         r_b  [4];
  logic [7:0]         r_y  [4];
  logic signed [31:0] r_us [4];
  logic signed [31:0] r_vs [4];

  function automatic logic [7:0] clip8(input logic signed [31:0] v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

  // One pixel converter shared across CMP0..CMP3, one pixel per cycle.
  logic [1:0]         w_pix;
  logic signed [31:0] w_rs, w_gs, w_bs;
  logic signed [31:0] w_ys, w_us, w_vs;
  logic [7:0]         w_ua, w_ub, w_va, w_vb;

  assign w_pix = 2'(r_state - S_CMP0);
  assign w_rs  = {24'd0, r_r[w_pix]};
  assign w_gs  = {24'd0, r_g[w_pix]};
  assign w_bs  = {24'd0, r_b[w_pix]};

  assign w_ys = 32'sd16843 * w_rs + 32'sd33030 * w_gs + 32'sd6423 * w_bs + 32'sd1048576;
  assign w_us = 32'sd8388608 - 32'sd9699 * w_rs - 32'sd19071 * w_gs + 32'sd28770 * w_bs;
  assign w_vs = 32'sd8388608 + 32'sd28770 * w_rs - 32'sd24117 * w_gs - 32'sd4653 * w_bs;

  assign w_ua = clip8((r_us[0] + r_us[1] + 32'sd65536) >>> 17);
  assign w_ub = clip8((r_us[2] + r_us[3] + 32'sd65536) >>> 17);
  assign w_va = clip8((r_vs[0] + r_vs[1] + 32'sd65536) >>> 17);
  assign w_vb = clip8((r_vs[2] + r_vs[3] + 32'sd65536) >>> 17);

  // NOTE: pixel and result registers carry no reset; every one is written in the
  // current iteration before it is read, so resetting them would only cost logic.
  always_ff @(posedge Clock) begin
    case (r_state)
      S_RD2:  {r_r[0], r_g[0]} <= SRAM_read_data;
      S_RD3:  {r_b[0], r_r[1]} <= SRAM_read_data;
      S_RD4:  {r_g[1], r_b[1]} <= SRAM_read_data;
      S_RD5:  {r_r[2], r_g[2]} <= SRAM_read_data;
      S_CAP0: {r_b[2], r_r[3]} <= SRAM_read_data;
      S_CAP1: {r_g[3], r_b[3]} <= SRAM_read_data;
      S_CMP0, S_CMP1, S_CMP2, S_CMP3: begin
        r_y[w_pix]  <= clip8((w_ys + 32'sd32768) >>> 16);
        r_us[w_pix] <= w_us;
        r_vs[w_pix] <= w_vs;
      end
      default: ;
    endcase
  end

  // SRAM outputs are registered on entry to the state that uses them.
  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state         <= S_IDLE;
      r_k             <= 16'd0;
      r_rgb_addr      <= RGB_START;
      r_y_addr        <= Y_START;
      Stop            <= 1'b0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state      <= S_RD0;
            SRAM_address <= r_rgb_addr;
          end
        end
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4: begin
          r_state      <= r_state + 5'd1;
          SRAM_address <= SRAM_address + 18'd1;
        end
        S_RD5, S_CAP0, S_CAP1, S_CMP0, S_CMP1, S_CMP2: begin
          r_state <= r_state + 5'd1;
        end
        S_CMP3: begin
          r_state         <= S_WR0;
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= r_y_addr;
          SRAM_write_data <= {r_y[0], r_y[1]};
        end
        S_WR0: begin
          r_state         <= S_WR1;
          SRAM_address    <= r_y_addr + 18'd1;
          SRAM_write_data <= {r_y[2], r_y[3]};
        end
        S_WR1: begin
          r_state         <= S_WR2;
          SRAM_address    <= U_START + {2'b00, r_k};
          SRAM_write_data <= {w_ua, w_ub};
        end
        S_WR2: begin
          r_state         <= S_WR3;
          SRAM_address    <= V_START + {2'b00, r_k};
          SRAM_write_data <= {w_va, w_vb};
        end
        S_WR3: begin
          SRAM_we_n <= 1'b1;
          if (r_k == LAST_K) begin
            r_state <= S_DONE;
            Stop    <= 1'b1;
          end else begin
            r_state      <= S_RD0;
            r_k          <= r_k + 16'd1;
            r_rgb_addr   <= r_rgb_addr + 18'd6;
            r_y_addr     <= r_y_addr + 18'd2;
            SRAM_address <= r_rgb_addr + 18'd6;
          end
        end
        S_DONE: begin
          Stop      <= 1'b1;
          SRAM_we_n <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
